// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: widths, reset vector, NOP encoding,
// fetch FSM states and the branch-op encoding used by the execute stage.
package fetch_stage_pkg;
   localparam int          DEF_BUS_WIDTH    = 32;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic {
      BOOT,
      RUN
   } fetch_state_e;

   // funct3 encodings of the conditional branches
   typedef enum logic [2:0] {
      B_BEQ  = 3'b000,
      B_BNE  = 3'b001,
      B_BLT  = 3'b100,
      B_BGE  = 3'b101,
      B_BLTU = 3'b110,
      B_BGEU = 3'b111
   } type_B_op_e;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. A flush turns the slot into a bubble (NOP, not valid)
// while keeping the PC, and it wins over a load.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int BUS_WIDTH = DEF_BUS_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 flush,
   input  logic [BUS_WIDTH-1:0] pc_in,
   input  logic [31:0]          instr_in,
   output logic [BUS_WIDTH-1:0] pc_out,
   output logic [31:0]          instr_out,
   output logic                 valid_out
);

   // Bubble on flush, capture on enable, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_out    <= '0;
         instr_out <= NOP_INSTR;
         valid_out <= 1'b0;
      end else if (flush) begin
         instr_out <= NOP_INSTR;
         valid_out <= 1'b0;
      end else if (en) begin
         pc_out    <= pc_in;
         instr_out <= instr_in;
         valid_out <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, handles stalls and execute-stage
// redirects, and feeds the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                   BUS_WIDTH    = DEF_BUS_WIDTH,
   parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR[BUS_WIDTH-1:0],
   parameter int                   CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic                 br_taken,
   input  logic [BUS_WIDTH-1:0] br_target,
   input  logic [31:0]          instr_in,
   output logic [BUS_WIDTH-1:0] pc_f,
   output logic [BUS_WIDTH-1:0] pc_d,
   output logic [31:0]          instr_d,
   output logic                 valid_d,
   output logic                 misalign_err,
   output logic [CNT_WIDTH-1:0] redirect_cnt
);

   fetch_state_e         state, state_next;
   logic [BUS_WIDTH-1:0] pc_next;
   logic                 load, flush, accept;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_next;
   end

   // Next PC and IF/ID control; stall beats redirect beats sequential fetch.
   // Redirects are ignored in BOOT since execute cannot hold a branch yet.
   always_comb begin
      state_next = state;
      pc_next    = pc_f;
      load       = 1'b0;
      flush      = 1'b0;
      accept     = 1'b0;
      case (state)
         BOOT: begin
            if (!stall) begin
               load       = 1'b1;
               pc_next    = pc_f + BUS_WIDTH'(4);
               state_next = RUN;
            end
         end
         RUN: begin
            if (!stall) begin
               if (br_taken) begin
                  accept  = 1'b1;
                  flush   = 1'b1;
                  pc_next = {br_target[BUS_WIDTH-1:2], 2'b00};
               end else begin
                  load    = 1'b1;
                  pc_next = pc_f + BUS_WIDTH'(4);
               end
            end
         end
         default: state_next = BOOT;
      endcase
   end

   // Fetch PC, misalignment pulse and saturating redirect counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_f         <= RESET_VECTOR;
         misalign_err <= 1'b0;
         redirect_cnt <= '0;
      end else begin
         pc_f         <= pc_next;
         misalign_err <= accept && (br_target[1:0] != 2'b00);
         if (accept && (redirect_cnt != '1))
            redirect_cnt <= redirect_cnt + CNT_WIDTH'(1);
      end
   end

   if_id_reg #(.BUS_WIDTH(BUS_WIDTH)) u_if_id (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (load),
      .flush     (flush),
      .pc_in     (pc_f),
      .instr_in  (instr_in),
      .pc_out    (pc_d),
      .instr_out (instr_d),
      .valid_out (valid_d)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus process queues hand-computed
// post-edge outputs, a monitor pops and compares them on the falling edge.
module tb_fetch_stage;

   localparam int CW = 4;  // narrow counter so saturation is reachable quickly

   typedef struct {
      logic [31:0]   pcf;
      logic [31:0]   pcd;
      logic [31:0]   ins;
      logic          v;
      logic          mis;
      logic [CW-1:0] cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stall, br_taken;
   logic [31:0]   br_target, instr_in;
   logic [31:0]   pc_f, pc_d, instr_d;
   logic          valid_d, misalign_err;
   logic [CW-1:0] redirect_cnt;

   exp_t  q[$];
   string nq[$];
   int    checks = 0;
   int    errors = 0;

   fetch_stage #(.BUS_WIDTH(32), .RESET_VECTOR(32'h0), .CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .instr_in     (instr_in),
      .pc_f         (pc_f),
      .pc_d         (pc_d),
      .instr_d      (instr_d),
      .valid_d      (valid_d),
      .misalign_err (misalign_err),
      .redirect_cnt (redirect_cnt)
   );

   always #5 clk = ~clk;

   task automatic push(input string name, input logic [31:0] pcf, input logic [31:0] pcd,
                       input logic [31:0] ins, input logic v, input logic mis,
                       input logic [CW-1:0] cnt);
      exp_t e;
      e.pcf = pcf; e.pcd = pcd; e.ins = ins; e.v = v; e.mis = mis; e.cnt = cnt;
      q.push_back(e);
      nq.push_back(name);
   endtask

   // one clock edge, then queue the state expected after it
   task automatic step(input string name, input logic [31:0] pcf, input logic [31:0] pcd,
                       input logic [31:0] ins, input logic v, input logic mis,
                       input logic [CW-1:0] cnt);
      @(posedge clk);
      #1;
      push(name, pcf, pcd, ins, v, mis, cnt);
   endtask

   // monitor: compare the oldest expectation against the outputs mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            exp_t  e;
            string n;
            e = q.pop_front();
            n = nq.pop_front();
            checks++;
            if (pc_f !== e.pcf || pc_d !== e.pcd || instr_d !== e.ins ||
                valid_d !== e.v || misalign_err !== e.mis || redirect_cnt !== e.cnt) begin
               errors++;
               $display("FAIL %s: got pc_f=%h pc_d=%h instr_d=%h valid_d=%b mis=%b cnt=%h, want pc_f=%h pc_d=%h instr_d=%h valid_d=%b mis=%b cnt=%h",
                        n, pc_f, pc_d, instr_d, valid_d, misalign_err, redirect_cnt,
                        e.pcf, e.pcd, e.ins, e.v, e.mis, e.cnt);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0; instr_in = 32'h93;
      push("reset", 32'h0, 32'h0, 32'h13, 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // boot and sequential fetch
      step("boot",  32'h04, 32'h00, 32'h93, 1, 0, 0);
      step("seq1",  32'h08, 32'h04, 32'h93, 1, 0, 0);
      step("seq2",  32'h0C, 32'h08, 32'h93, 1, 0, 0);
      step("seq3",  32'h10, 32'h0C, 32'h93, 1, 0, 0);
      instr_in = 32'h33;
      step("seq4",  32'h14, 32'h10, 32'h33, 1, 0, 0);
      step("seq5",  32'h18, 32'h14, 32'h33, 1, 0, 0);
      step("seq6",  32'h1C, 32'h18, 32'h33, 1, 0, 0);
      step("seq7",  32'h20, 32'h1C, 32'h33, 1, 0, 0);

      // aligned redirect at pc_f=0x20
      br_taken = 1'b1; br_target = 32'h104;
      step("redir",     32'h104, 32'h1C,  32'h13, 0, 0, 1);
      br_taken = 1'b0; instr_in = 32'hAB;
      step("redir_tgt", 32'h108, 32'h104, 32'hAB, 1, 0, 1);

      // stall masks a pending redirect
      stall = 1'b1; br_taken = 1'b1; br_target = 32'h300;
      for (int i = 0; i < 3; i++)
         step("stall_hold", 32'h108, 32'h104, 32'hAB, 1, 0, 1);
      stall = 1'b0;
      step("stall_redir", 32'h300, 32'h104, 32'h13, 0, 0, 2);
      br_taken = 1'b0; instr_in = 32'h55;
      step("stall_once",  32'h304, 32'h300, 32'h55, 1, 0, 2);

      // misaligned target: pulse lasts one cycle
      br_taken = 1'b1; br_target = 32'h203;
      step("misalign",     32'h200, 32'h300, 32'h13, 0, 1, 3);
      br_taken = 1'b0; instr_in = 32'h66;
      step("misalign_end", 32'h204, 32'h200, 32'h66, 1, 0, 3);

      // back-to-back redirects up to saturation
      br_taken = 1'b1; br_target = 32'h400;
      for (int i = 0; i < 12; i++)
         step("cnt_ramp", 32'h400, 32'h200, 32'h13, 0, 0, CW'(4 + i));
      br_target = 32'hFFFF_FFFC;
      step("cnt_sat1", 32'hFFFF_FFFC, 32'h200, 32'h13, 0, 0, 4'hF);
      step("cnt_sat2", 32'hFFFF_FFFC, 32'h200, 32'h13, 0, 0, 4'hF);

      // PC wrap on sequential fetch
      br_taken = 1'b0; instr_in = 32'h77;
      step("wrap",      32'h0, 32'hFFFF_FFFC, 32'h77, 1, 0, 4'hF);
      step("post_wrap", 32'h4, 32'h0,         32'h77, 1, 0, 4'hF);

      // async reset mid-redirect, checked before the next rising edge
      br_taken = 1'b1; br_target = 32'h500;
      @(posedge clk); #2;
      rst_n = 1'b0;
      push("async_reset", 32'h0, 32'h0, 32'h13, 0, 0, 0);

      // stall and redirect in BOOT
      stall = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step("boot_stall", 32'h0, 32'h0, 32'h13, 0, 0, 0);
      stall = 1'b0; br_target = 32'h600; instr_in = 32'h99;
      step("boot_br_ign", 32'h4, 32'h0, 32'h99, 1, 0, 0);
      br_taken = 1'b0;
      step("boot_run",    32'h8, 32'h4, 32'h99, 1, 0, 0);

      // let the monitor drain, bounded
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
